pipe_if_stage: RTL and testbench
================================

PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 The block SHALL have one clock, `clock`; reset is synchronous and active-high, on port `reset`.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high reset.
- `wpcir`  in  1  1 = PC and IF/ID register advance; 0 = hold (load-use stall).
- `bubble`  in  1  1 = normal; 0 = taken control transfer, squash the instruction being latched into IF/ID.
- `pcsource`  in  2  next-PC select from decode.
- `bpc`  in  32  branch target.
- `ra`  in  32  jr target (forwarded rs value).
- `jpc`  in  32  j/jal target.
- `ins`  in  32  instruction word read from instruction memory at `pc`.
- `pc`  out  32  current fetch address.
- `dpc4`  out  32  IF/ID latched pc+4.
- `dinst`  out  32  IF/ID latched instruction.
- `dvalid`  out  1  IF/ID holds a real (non-squashed) instruction.
- `fetch_cnt`  out  32  count of instructions accepted into ID.
- `stall_cnt`  out  32  count of stall cycles.

Function
REQ-003 All outputs SHALL be registered, and each SHALL update only on the rising edge of `clock`.
REQ-004 `pc4` (internal) SHALL be `pc`+4, modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-005 The next PC SHALL be selected by `pcsource`:
- 00 → `pc4`
- 01 → `bpc`
- 10 → `ra`
- 11 → `jpc`
REQ-006 The target values SHALL be taken unmodified; no alignment checking SHALL be applied.
REQ-007 The per-edge priority SHALL be: `reset` > hold (`wpcir`=0) > flush (`bubble`=0) > normal.
REQ-008 Hold (`wpcir`=0, `reset`=0): `pc`, `dpc4`, `dinst`, `dvalid` and `fetch_cnt` SHALL keep their values, and `stall_cnt` SHALL increment by 1.
REQ-009 Hold SHALL ignore `pcsource` and `bubble` in that cycle; decode re-evaluates the branch on the next cycle.
REQ-010 Flush (`wpcir`=1, `bubble`=0): `pc` SHALL load the selected next PC, and the IF/ID register SHALL load `dinst`=0x00000000 (nop), `dpc4`=0 and `dvalid`=0.
REQ-011 In a flush cycle, `fetch_cnt` and `stall_cnt` SHALL be unchanged.
REQ-012 Normal (`wpcir`=1, `bubble`=1): `pc` SHALL load the selected next PC, and the IF/ID register SHALL load `dinst`=`ins`, `dpc4`=`pc4` and `dvalid`=1.
REQ-013 In a normal cycle, `fetch_cnt` SHALL increment by 1.
REQ-014 Instruction memory SHALL be combinational: `ins` is valid in the same cycle as `pc`, so the fetch-to-ID latency is exactly 1 cycle.
REQ-015 Both counters SHALL wrap from 0xFFFFFFFF to 0 silently.
REQ-016 Back-to-back stalls SHALL be unbounded: `pc` is held for as many cycles as `wpcir` stays 0.
REQ-017 A stall immediately followed by a flush SHALL apply the flush on the first edge where `wpcir`=1.
REQ-018 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-019 On a clock edge with `reset`=1, the block SHALL set `pc`, `dpc4`, `dinst`, `fetch_cnt` and `stall_cnt` to 0, and `dvalid` to 0.
REQ-020 After reset is released, the first fetch SHALL be from address 0x00000000.
REQ-021 A reset asserted mid-stall or mid-flush SHALL override the stall or flush in that same edge.
REQ-022 `reset` held for N cycles SHALL keep all outputs at their reset values, and neither counter SHALL count during reset.

Verification
REQ-023 Sequential fetch: reset, then 3 edges with `wpcir`=1, `bubble`=1, `pcsource`=00, `ins`=0x20010005 → `pc`=0x0000000C, `dpc4`=0x0000000C, `dinst`=0x20010005, `dvalid`=1, `fetch_cnt`=3.
REQ-024 Load-use stall: with `pc`=0x10, `wpcir`=0 for 2 edges → `pc`=0x10 and IF/ID unchanged, `stall_cnt`=2; then `wpcir`=1 → `pc`=0x14.
REQ-025 Taken branch flush: `pc`=0x20, `pcsource`=01, `bpc`=0x40, `bubble`=0 → `pc`=0x40, `dinst`=0, `dvalid`=0, `fetch_cnt` unchanged.
REQ-026 jr and j: `pcsource`=10 with `ra`=0x0000ABC0 → `pc`=0xABC0; then `pcsource`=11 with `jpc`=0x00400000 → `pc`=0x00400000.
REQ-027 Stall dominates flush: `wpcir`=0, `bubble`=0, `pcsource`=11 → nothing changes except `stall_cnt`+1.
REQ-028 Reset mid-run and wrap: assert `reset` during a stall → all outputs 0 on that edge; separately, `pc`=0xFFFFFFFC with a normal fetch → `pc`=0, `dpc4`=0.

Source files
------------

// File: rtl/pipe_if_stage.sv
// Instruction fetch stage of a five-stage pipeline: the program counter,
// next-PC selection and the IF/ID pipeline register, plus counters for
// instructions accepted into decode and load-use stall cycles.
//
// Each edge falls into one of four cases, highest priority first:
//   reset  - everything to zero, first fetch after release is from 0x0
//   hold   - wpcir = 0: PC and IF/ID frozen, stall counter advances
//   flush  - bubble = 0: PC takes the new target, IF/ID loads a nop
//   normal - PC takes the selected next PC, IF/ID loads {pc+4, ins}
// Instruction memory is combinational, so ins belongs to the current pc
// and fetch-to-decode latency is exactly one cycle. Every output is a
// flop, so there is no combinational path from any input to any output.

module pipe_if_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        wpcir,
    input  logic        bubble,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] ra,
    input  logic [31:0] jpc,
    input  logic [31:0] ins,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] dinst,
    output logic        dvalid,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    // Encoding of the next-PC select coming from decode.
    typedef enum logic [1:0] {
        SEL_PC4 = 2'b00,
        SEL_BR  = 2'b01,
        SEL_JR  = 2'b10,
        SEL_J   = 2'b11
    } pc_sel_e;

    // The nop injected into IF/ID when a taken control transfer squashes
    // the instruction that was being fetched alongside it.
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic [31:0] pc4;
    logic [31:0] next_pc;

    // Sequential address and next-PC mux; targets pass through unmodified,
    // with no alignment check, and pc+4 wraps naturally at 2^32.
    always_comb begin
        // NOTE: every signal driven here gets a default before the case so
        // that no path leaves it unassigned, which would infer a latch.
        next_pc = 32'h0000_0000;
        pc4     = pc + 32'd4;
        unique case (pc_sel_e'(pcsource))
            SEL_PC4: next_pc = pc4;
            SEL_BR:  next_pc = bpc;
            SEL_JR:  next_pc = ra;
            SEL_J:   next_pc = jpc;
            default: next_pc = pc4;
        endcase
    end

    // PC, IF/ID register and counters: reset > hold > flush > normal.
    always_ff @(posedge clock) begin
        // NOTE: all state here uses non-blocking assignments so every
        // register samples the pre-edge values of the others (pc4 and
        // next_pc are derived from the old pc, not the one being written).
        if (reset) begin
            pc        <= 32'h0000_0000;
            dpc4      <= 32'h0000_0000;
            dinst     <= 32'h0000_0000;
            dvalid    <= 1'b0;
            fetch_cnt <= 32'h0000_0000;
            stall_cnt <= 32'h0000_0000;
        end else if (!wpcir) begin
            // Load-use hold: pcsource and bubble are ignored; decode
            // re-evaluates the branch once the stall clears.
            stall_cnt <= stall_cnt + 32'd1;
        end else if (!bubble) begin
            // Taken control transfer: redirect and squash the wrong-path
            // instruction. Neither counter moves.
            pc     <= next_pc;
            dpc4   <= 32'h0000_0000;
            dinst  <= NOP;
            dvalid <= 1'b0;
        end else begin
            pc        <= next_pc;
            dpc4      <= pc4;
            dinst     <= ins;
            dvalid    <= 1'b1;
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed bench for pipe_if_stage. Inputs change 1 ns after a rising edge
// and outputs are sampled at that same point, well away from the next edge.
// Expected values are hand-computed for the fixed vector sequence below,
// which runs as one continuous story so that counter values carry over.

module tb_pipe_if_stage;

    logic        clock;
    logic        reset;
    logic        wpcir;
    logic        bubble;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] ra;
    logic [31:0] jpc;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] dpc4;
    logic [31:0] dinst;
    logic        dvalid;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_if_stage dut (
        .clock     (clock),
        .reset     (reset),
        .wpcir     (wpcir),
        .bubble    (bubble),
        .pcsource  (pcsource),
        .bpc       (bpc),
        .ra        (ra),
        .jpc       (jpc),
        .ins       (ins),
        .pc        (pc),
        .dpc4      (dpc4),
        .dinst     (dinst),
        .dvalid    (dvalid),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wpcir = 1'b1; bubble = 1'b1; pcsource = 2'b00;
        bpc = 32'h0; ra = 32'h0; jpc = 32'h0; ins = 32'h2001_0005;
        tick(); tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        checks++; if (dpc4 !== 32'h0) begin errors++; $display("FAIL reset_dpc4 got %h exp %h", dpc4, 32'h0); end
        checks++; if (dinst !== 32'h0) begin errors++; $display("FAIL reset_dinst got %h exp %h", dinst, 32'h0); end
        checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b exp %b", dvalid, 1'b0); end
        checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_fetch_cnt got %0d exp %0d", fetch_cnt, 0); end
        checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp %0d", stall_cnt, 0); end
    endtask

    task automatic test_sequential();
        reset = 1'b0; wpcir = 1'b1; bubble = 1'b1; pcsource = 2'b00; ins = 32'h2001_0005;
        tick();
        checks++; if (dpc4 !== 32'h4) begin errors++; $display("FAIL seq_first_dpc4 got %h exp %h", dpc4, 32'h4); end
        tick(); tick();
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq_pc got %h exp %h", pc, 32'hC); end
        checks++; if (dpc4 !== 32'hC) begin errors++; $display("FAIL seq_dpc4 got %h exp %h", dpc4, 32'hC); end
        checks++; if (dinst !== 32'h2001_0005) begin errors++; $display("FAIL seq_dinst got %h exp %h", dinst, 32'h2001_0005); end
        checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL seq_dvalid got %b exp %b", dvalid, 1'b1); end
        checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL seq_fetch_cnt got %0d exp %0d", fetch_cnt, 3); end
    endtask

    task automatic test_stall();
        ins = 32'h8C22_0000;
        tick();  // pc 0xC -> 0x10, fetch_cnt 4
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_setup_pc got %h exp %h", pc, 32'h10); end
        wpcir = 1'b0; ins = 32'hDEAD_BEEF; pcsource = 2'b01; bpc = 32'h0000_0800;
        tick(); tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_pc got %h exp %h", pc, 32'h10); end
        checks++; if (dpc4 !== 32'h10) begin errors++; $display("FAIL stall_dpc4 got %h exp %h", dpc4, 32'h10); end
        checks++; if (dinst !== 32'h8C22_0000) begin errors++; $display("FAIL stall_dinst got %h exp %h", dinst, 32'h8C22_0000); end
        checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL stall_dvalid got %b exp %b", dvalid, 1'b1); end
        checks++; if (fetch_cnt !== 32'd4) begin errors++; $display("FAIL stall_fetch_cnt got %0d exp %0d", fetch_cnt, 4); end
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL stall_stall_cnt got %0d exp %0d", stall_cnt, 2); end
        wpcir = 1'b1; pcsource = 2'b00; ins = 32'h0022_1820;
        tick();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL unstall_pc got %h exp %h", pc, 32'h14); end
        checks++; if (dinst !== 32'h0022_1820) begin errors++; $display("FAIL unstall_dinst got %h exp %h", dinst, 32'h0022_1820); end
        checks++; if (dpc4 !== 32'h14) begin errors++; $display("FAIL unstall_dpc4 got %h exp %h", dpc4, 32'h14); end
        checks++; if (fetch_cnt !== 32'd5) begin errors++; $display("FAIL unstall_fetch_cnt got %0d exp %0d", fetch_cnt, 5); end
    endtask

    task automatic test_flush();
        ins = 32'h1000_0003;
        for (int i = 0; i < 3; i++) tick();  // 0x14 -> 0x20, fetch_cnt 8
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL flush_setup_pc got %h exp %h", pc, 32'h20); end
        pcsource = 2'b01; bpc = 32'h40; bubble = 1'b0; ins = 32'hAAAA_5555;
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL flush_pc got %h exp %h", pc, 32'h40); end
        checks++; if (dinst !== 32'h0) begin errors++; $display("FAIL flush_dinst got %h exp %h", dinst, 32'h0); end
        checks++; if (dpc4 !== 32'h0) begin errors++; $display("FAIL flush_dpc4 got %h exp %h", dpc4, 32'h0); end
        checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL flush_dvalid got %b exp %b", dvalid, 1'b0); end
        checks++; if (fetch_cnt !== 32'd8) begin errors++; $display("FAIL flush_fetch_cnt got %0d exp %0d", fetch_cnt, 8); end
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL flush_stall_cnt got %0d exp %0d", stall_cnt, 2); end
    endtask

    task automatic test_jr_j();
        bubble = 1'b1; pcsource = 2'b10; ra = 32'h0000_ABC0; ins = 32'h03E0_0008;
        tick();
        checks++; if (pc !== 32'h0000_ABC0) begin errors++; $display("FAIL jr_pc got %h exp %h", pc, 32'h0000_ABC0); end
        checks++; if (dpc4 !== 32'h44) begin errors++; $display("FAIL jr_dpc4 got %h exp %h", dpc4, 32'h44); end
        checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL jr_dvalid got %b exp %b", dvalid, 1'b1); end
        pcsource = 2'b11; jpc = 32'h0040_0000; ins = 32'h0C10_0000;
        tick();
        checks++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL j_pc got %h exp %h", pc, 32'h0040_0000); end
        checks++; if (dpc4 !== 32'h0000_ABC4) begin errors++; $display("FAIL j_dpc4 got %h exp %h", dpc4, 32'h0000_ABC4); end
        checks++; if (dinst !== 32'h0C10_0000) begin errors++; $display("FAIL j_dinst got %h exp %h", dinst, 32'h0C10_0000); end
        checks++; if (fetch_cnt !== 32'd10) begin errors++; $display("FAIL j_fetch_cnt got %0d exp %0d", fetch_cnt, 10); end
    endtask

    task automatic test_stall_dominates();
        wpcir = 1'b0; bubble = 1'b0; pcsource = 2'b11; jpc = 32'h0000_1234; ins = 32'h1234_5678;
        tick();
        checks++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL dom_pc got %h exp %h", pc, 32'h0040_0000); end
        checks++; if (dinst !== 32'h0C10_0000) begin errors++; $display("FAIL dom_dinst got %h exp %h", dinst, 32'h0C10_0000); end
        checks++; if (dpc4 !== 32'h0000_ABC4) begin errors++; $display("FAIL dom_dpc4 got %h exp %h", dpc4, 32'h0000_ABC4); end
        checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL dom_dvalid got %b exp %b", dvalid, 1'b1); end
        checks++; if (fetch_cnt !== 32'd10) begin errors++; $display("FAIL dom_fetch_cnt got %0d exp %0d", fetch_cnt, 10); end
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL dom_stall_cnt got %0d exp %0d", stall_cnt, 3); end
    endtask

    task automatic test_stall_then_flush();
        wpcir = 1'b0; bubble = 1'b0; pcsource = 2'b01; bpc = 32'h100;
        tick();  // stall_cnt 4
        wpcir = 1'b1;
        tick();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL sf_pc got %h exp %h", pc, 32'h100); end
        checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL sf_dvalid got %b exp %b", dvalid, 1'b0); end
        checks++; if (dinst !== 32'h0) begin errors++; $display("FAIL sf_dinst got %h exp %h", dinst, 32'h0); end
        checks++; if (fetch_cnt !== 32'd10) begin errors++; $display("FAIL sf_fetch_cnt got %0d exp %0d", fetch_cnt, 10); end
        checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL sf_stall_cnt got %0d exp %0d", stall_cnt, 4); end
    endtask

    task automatic test_reset_mid_run();
        bubble = 1'b1; pcsource = 2'b00; ins = 32'h2222_2222;
        tick();  // normal: pc 0x104, valid instruction in IF/ID, fetch_cnt 11
        wpcir = 1'b0; reset = 1'b1;
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_stall_pc got %h exp %h", pc, 32'h0); end
        checks++; if (dinst !== 32'h0) begin errors++; $display("FAIL rst_stall_dinst got %h exp %h", dinst, 32'h0); end
        checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL rst_stall_dvalid got %b exp %b", dvalid, 1'b0); end
        checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_stall_stall_cnt got %0d exp %0d", stall_cnt, 0); end
        checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL rst_stall_fetch_cnt got %0d exp %0d", fetch_cnt, 0); end
        // Held reset with both stall and normal-fetch stimulus: nothing counts.
        tick();
        wpcir = 1'b1;
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_hold_pc got %h exp %h", pc, 32'h0); end
        checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL rst_hold_fetch_cnt got %0d exp %0d", fetch_cnt, 0); end
        checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_hold_stall_cnt got %0d exp %0d", stall_cnt, 0); end
        reset = 1'b0; ins = 32'h3333_3333;
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL rst_release_pc got %h exp %h", pc, 32'h4); end
        checks++; if (dpc4 !== 32'h4) begin errors++; $display("FAIL rst_release_dpc4 got %h exp %h", dpc4, 32'h4); end
        checks++; if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL rst_release_fetch_cnt got %0d exp %0d", fetch_cnt, 1); end
    endtask

    task automatic test_wrap_and_unaligned();
        pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
        tick();  // fetch_cnt 2
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup_pc got %h exp %h", pc, 32'hFFFF_FFFC); end
        pcsource = 2'b00; ins = 32'h1111_1111;
        tick();  // fetch_cnt 3
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp %h", pc, 32'h0); end
        checks++; if (dpc4 !== 32'h0) begin errors++; $display("FAIL wrap_dpc4 got %h exp %h", dpc4, 32'h0); end
        checks++; if (dvalid !== 1'b1) begin errors++; $display("FAIL wrap_dvalid got %b exp %b", dvalid, 1'b1); end
        checks++; if (dinst !== 32'h1111_1111) begin errors++; $display("FAIL wrap_dinst got %h exp %h", dinst, 32'h1111_1111); end
        pcsource = 2'b01; bpc = 32'h0000_0003;
        tick();  // fetch_cnt 4
        checks++; if (pc !== 32'h3) begin errors++; $display("FAIL unaligned_pc got %h exp %h", pc, 32'h3); end
        checks++; if (fetch_cnt !== 32'd4) begin errors++; $display("FAIL unaligned_fetch_cnt got %0d exp %0d", fetch_cnt, 4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_jr_j();
        test_stall_dominates();
        test_stall_then_flush();
        test_reset_mid_run();
        test_wrap_and_unaligned();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
